// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache/LSB request ports and the shared byte-wide RAM/IO bus
interface mem_arbiter_if #(
    parameter int BLOCK_WIDTH = 2
);
    localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;
    logic [7:0]                 mem_din;
    logic [7:0]                 mem_dout;
    logic [31:0]                mem_a;
    logic                       mem_wr;
    logic                       io_buffer_full;
    logic                       icache_req;
    logic [31:0]                icache_addr;
    logic                       icache_done;
    logic [32*BLOCK_SIZE-1:0]   icache_data;
    logic                       lsb_req;
    logic                       lsb_we;
    logic [31:0]                lsb_addr;
    logic [1:0]                 lsb_width;
    logic                       lsb_signed;
    logic [31:0]                lsb_wdata;
    logic                       lsb_done;
    logic [31:0]                lsb_rdata;
    modport slave (
        input  mem_din, io_buffer_full, icache_req, icache_addr,
               lsb_req, lsb_we, lsb_addr, lsb_width, lsb_signed, lsb_wdata,
        output mem_dout, mem_a, mem_wr, icache_done, icache_data, lsb_done, lsb_rdata
    );
    modport master (
        output mem_din, io_buffer_full, icache_req, icache_addr,
               lsb_req, lsb_we, lsb_addr, lsb_width, lsb_signed, lsb_wdata,
        input  mem_dout, mem_a, mem_wr, icache_done, icache_data, lsb_done, lsb_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial sequencer sharing one 8-bit RAM/IO port between icache refills and LSB accesses
module mem_arbiter #(
    parameter int BLOCK_WIDTH = 2,
    parameter int BLOCK_SIZE  = 1 << BLOCK_WIDTH
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         flush_in,
    output logic         busy,
    mem_arbiter_if.slave bus
);
    localparam int CW = BLOCK_WIDTH + 3;
    localparam int DW = 32 * BLOCK_SIZE;
    localparam int OW = BLOCK_WIDTH + 2;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] IC_N = CW'(4 * BLOCK_SIZE);
    localparam logic [31:0] IC_MASK = 32'((1 << OW) - 1);

    typedef enum logic [1:0] {IDLE, IC_RD, LS_RD, LS_WR} state_t;

    state_t          state;
    logic            last_ic;
    logic [31:0]     base;
    logic [31:0]     wdata;
    logic [CW-1:0]   n;
    logic [CW-1:0]   icnt;
    logic [CW-1:0]   ccnt;
    logic            pend;
    logic            sgn;
    logic [1:0]      width;
    logic [DW-1:0]   bytes;
    logic [DW-1:0]   bytes_nx;
    logic [CW-1:0]   idx;
    logic [31:0]     word;
    logic [31:0]     ld;
    logic            ic_ok;
    logic            ls_ok;
    logic            grant_ic;
    logic            stall;

    // arbitration, bus drive (pause points mem_a at the oldest uncaptured byte) and load extension
    always_comb begin
        ic_ok         = bus.icache_req && !bus.icache_done;
        ls_ok         = bus.lsb_req && !bus.lsb_done;
        grant_ic      = ic_ok && (!ls_ok || !last_ic);
        idx           = (rdy_in || state == LS_WR) ? icnt : ccnt;
        bus.mem_a     = (state == IDLE) ? 32'd0 : base + 32'(idx);
        stall         = state == LS_WR && bus.mem_a[17:16] == 2'b11 && bus.io_buffer_full;
        bus.mem_wr    = state == LS_WR && rdy_in && !stall;
        bus.mem_dout  = (state == LS_WR && rdy_in) ? wdata[{icnt[1:0], 3'b000} +: 8] : 8'd0;
        busy          = state != IDLE;
        bytes_nx      = bytes;
        bytes_nx[{ccnt[CW-2:0], 3'b000} +: 8] = bus.mem_din;
        word          = bytes_nx[31:0];
        ld            = width == 2'b00 ? {{24{sgn & word[7]}}, word[7:0]} :
                        width == 2'b01 ? {{16{sgn & word[15]}}, word[15:0]} : word;
    end

    // sequencer FSM: grant, byte issue/capture, completion pulses and result registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            last_ic         <= 1'b0;
            base            <= '0;
            wdata           <= '0;
            n               <= '0;
            icnt            <= '0;
            ccnt            <= '0;
            pend            <= 1'b0;
            sgn             <= 1'b0;
            width           <= '0;
            bytes           <= '0;
            bus.icache_done <= 1'b0;
            bus.icache_data <= '0;
            bus.lsb_done    <= 1'b0;
            bus.lsb_rdata   <= '0;
        end else begin
            bus.icache_done <= 1'b0;
            bus.lsb_done    <= 1'b0;
            if (!rdy_in) begin
                pend <= 1'b0;
                if (state != LS_WR) icnt <= ccnt;
            end else begin
                case (state)
                    IDLE: if (!flush_in && (ic_ok || ls_ok)) begin
                        icnt    <= '0;
                        ccnt    <= '0;
                        pend    <= 1'b0;
                        last_ic <= grant_ic;
                        base    <= grant_ic ? (bus.icache_addr & ~IC_MASK) : bus.lsb_addr;
                        n       <= grant_ic ? IC_N : bus.lsb_width == 2'b00 ? CW'(1) :
                                   bus.lsb_width == 2'b01 ? CW'(2) : CW'(4);
                        state   <= grant_ic ? IC_RD : (bus.lsb_we ? LS_WR : LS_RD);
                        width   <= bus.lsb_width;
                        sgn     <= bus.lsb_signed;
                        wdata   <= bus.lsb_wdata;
                    end
                    LS_WR: if (!stall) begin
                        icnt <= icnt + ONE;
                        if (icnt == n - ONE) begin
                            state        <= IDLE;
                            bus.lsb_done <= 1'b1;
                        end
                    end
                    default: if (flush_in) begin
                        state <= IDLE;
                    end else begin
                        pend <= icnt != n;
                        if (icnt != n) icnt <= icnt + ONE;
                        if (pend) begin
                            bytes <= bytes_nx;
                            ccnt  <= ccnt + ONE;
                            if (ccnt == n - ONE) begin
                                state <= IDLE;
                                if (state == IC_RD) begin
                                    bus.icache_done <= 1'b1;
                                    bus.icache_data <= bytes_nx;
                                end else begin
                                    bus.lsb_done  <= 1'b1;
                                    bus.lsb_rdata <= ld;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of timing, arbitration, extension, IO stall, pause and flush
module tb_mem_arbiter;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic flush_in;
    logic busy;
    int compared = 0;
    int mismatched = 0;
    int wr_cnt = 0;
    int ic_done_cnt = 0;
    logic [31:0] last_wa = '0;
    logic [7:0]  last_wd = '0;

    mem_arbiter_if #(.BLOCK_WIDTH(2)) bus ();

    mem_arbiter #(.BLOCK_WIDTH(2)) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rdy_in  (rdy_in),
        .flush_in(flush_in),
        .busy    (busy),
        .bus     (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 8'h11;
            32'h0000_0101: return 8'h22;
            32'h0000_0102: return 8'h33;
            32'h0000_0103: return 8'h44;
            32'h0000_0110: return 8'h80;
            32'h0000_0120: return 8'h01;
            32'h0000_0121: return 8'h80;
            32'hFFFF_FFFE: return 8'h01;
            32'hFFFF_FFFF: return 8'h02;
            32'h0000_0000: return 8'h03;
            32'h0000_0001: return 8'h04;
            default: return (a[31:4] == 28'h20) ? 8'hA0 + {4'h0, a[3:0]} : a[7:0] ^ 8'hC3;
        endcase
    endfunction

    // RAM model: one-cycle read latency
    always @(posedge clk_in) bus.mem_din <= rom(bus.mem_a);

    // bus monitor: write strobes and refill completions
    always @(negedge clk_in) begin
        if (bus.mem_wr) begin
            wr_cnt++;
            last_wa = bus.mem_a;
            last_wd = bus.mem_dout;
        end
        if (bus.icache_done) ic_done_cnt++;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input bit ic, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(ic ? bus.icache_done : bus.lsb_done) && cyc < 200);
    endtask

    task automatic lsb_set(input logic we, input logic [31:0] a, input logic [1:0] w,
                           input logic s, input logic [31:0] d);
        bus.lsb_we     = we;
        bus.lsb_addr   = a;
        bus.lsb_width  = w;
        bus.lsb_signed = s;
        bus.lsb_wdata  = d;
        bus.lsb_req    = 1'b1;
    endtask

    task automatic lsb_op(input string tag, input logic we, input logic [31:0] a, input logic [1:0] w,
                          input logic s, input logic [31:0] d, input int exp_cyc, input logic [31:0] exp_data);
        int cyc;
        lsb_set(we, a, w, s, d);
        wait_done(1'b0, cyc);
        bus.lsb_req = 1'b0;
        chk({tag, "_cyc"}, 128'(cyc), 128'(exp_cyc));
        if (!we) chk({tag, "_data"}, 128'(bus.lsb_rdata), 128'(exp_data));
        tick();
    endtask

    initial begin
        int cyc;
        int w0;
        int ic0;
        logic [127:0] blk;
        blk = {32'hAFAEADAC, 32'hABAAA9A8, 32'hA7A6A5A4, 32'hA3A2A1A0};
        rst_in = 1'b0;
        rdy_in = 1'b1;
        flush_in = 1'b0;
        bus.io_buffer_full = 1'b0;
        bus.icache_req = 1'b0;
        bus.icache_addr = '0;
        bus.lsb_req = 1'b0;
        bus.lsb_we = 1'b0;
        bus.lsb_addr = '0;
        bus.lsb_width = '0;
        bus.lsb_signed = 1'b0;
        bus.lsb_wdata = '0;
        tick();
        tick();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_lsb_done", 128'(bus.lsb_done), 128'(0));
        chk("rst_ic_done", 128'(bus.icache_done), 128'(0));
        chk("rst_mem_wr", 128'(bus.mem_wr), 128'(0));
        chk("rst_mem_a", 128'(bus.mem_a), 128'(0));
        chk("rst_rdata", 128'(bus.lsb_rdata), 128'(0));
        chk("rst_icdata", bus.icache_data, 128'(0));
        rst_in = 1'b1;
        tick();

        lsb_set(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("word_mem_a", 128'(bus.mem_a), 128'(32'h100 + i));
        end
        tick();
        chk("word_no_early_done", 128'(bus.lsb_done), 128'(0));
        tick();
        chk("word_done_t6", 128'(bus.lsb_done), 128'(1));
        chk("word_data", 128'(bus.lsb_rdata), 128'(32'h44332211));
        bus.lsb_req = 1'b0;
        tick();
        chk("done_one_cycle", 128'(bus.lsb_done), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));

        lsb_op("sbyte", 1'b0, 32'h110, 2'b00, 1'b1, 32'h0, 3, 32'hFFFFFF80);
        lsb_op("ubyte", 1'b0, 32'h110, 2'b00, 1'b0, 32'h0, 3, 32'h00000080);
        lsb_op("shalf", 1'b0, 32'h120, 2'b01, 1'b1, 32'h0, 4, 32'hFFFF8001);
        lsb_op("uhalf", 1'b0, 32'h120, 2'b01, 1'b0, 32'h0, 4, 32'h00008001);
        lsb_op("w11", 1'b0, 32'h100, 2'b11, 1'b0, 32'h0, 6, 32'h44332211);

        bus.icache_addr = 32'h20B;
        bus.icache_req = 1'b1;
        lsb_set(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
        tick();
        chk("arb_busy", 128'(busy), 128'(1));
        wait_done(1'b1, cyc);
        bus.icache_req = 1'b0;
        chk("arb_ic_cyc", 128'(cyc + 1), 128'(18));
        chk("arb_ic_data", bus.icache_data, blk);
        chk("arb_lsb_waiting", 128'(bus.lsb_done), 128'(0));
        wait_done(1'b0, cyc);
        bus.lsb_req = 1'b0;
        chk("arb_lsb_cyc", 128'(cyc), 128'(6));
        chk("arb_lsb_data", 128'(bus.lsb_rdata), 128'(32'h44332211));
        tick();

        w0 = wr_cnt;
        bus.io_buffer_full = 1'b1;
        lsb_set(1'b1, 32'h30000, 2'b00, 1'b0, 32'h41);
        tick();
        tick();
        tick();
        chk("io_stall_wr", 128'(bus.mem_wr), 128'(0));
        chk("io_stall_a", 128'(bus.mem_a), 128'(32'h30000));
        tick();
        bus.io_buffer_full = 1'b0;
        wait_done(1'b0, cyc);
        bus.lsb_req = 1'b0;
        chk("io_done_cyc", 128'(cyc + 4), 128'(5));
        tick();
        chk("io_wr_once", 128'(wr_cnt - w0), 128'(1));
        chk("io_wr_addr", 128'(last_wa), 128'(32'h30000));
        chk("io_wr_data", 128'(last_wd), 128'(8'h41));

        lsb_set(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
        tick();
        tick();
        tick();
        rdy_in = 1'b0;
        #1;
        chk("pause_wr", 128'(bus.mem_wr), 128'(0));
        chk("pause_a", 128'(bus.mem_a), 128'(32'h101));
        tick();
        chk("pause_no_done", 128'(bus.lsb_done), 128'(0));
        tick();
        rdy_in = 1'b1;
        wait_done(1'b0, cyc);
        bus.lsb_req = 1'b0;
        chk("pause_cyc", 128'(cyc + 5), 128'(9));
        chk("pause_data", 128'(bus.lsb_rdata), 128'(32'h44332211));
        tick();

        ic0 = ic_done_cnt;
        bus.icache_addr = 32'h300;
        bus.icache_req = 1'b1;
        tick();
        tick();
        tick();
        flush_in = 1'b1;
        bus.icache_req = 1'b0;
        tick();
        flush_in = 1'b0;
        chk("flush_ic_idle", 128'(busy), 128'(0));
        repeat (25) tick();
        chk("flush_ic_no_done", 128'(ic_done_cnt - ic0), 128'(0));
        chk("flush_ic_data_held", bus.icache_data, blk);

        w0 = wr_cnt;
        lsb_set(1'b1, 32'h140, 2'b01, 1'b0, 32'h1234BEEF);
        tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        wait_done(1'b0, cyc);
        bus.lsb_req = 1'b0;
        chk("flush_st_cyc", 128'(cyc + 2), 128'(3));
        tick();
        chk("flush_st_wrs", 128'(wr_cnt - w0), 128'(2));
        chk("flush_st_addr", 128'(last_wa), 128'(32'h141));
        chk("flush_st_data", 128'(last_wd), 128'(8'hBE));

        flush_in = 1'b1;
        lsb_set(1'b0, 32'h110, 2'b00, 1'b1, 32'h0);
        tick();
        flush_in = 1'b0;
        chk("flush_idle_nogrant", 128'(busy), 128'(0));
        wait_done(1'b0, cyc);
        bus.lsb_req = 1'b0;
        chk("flush_idle_cyc", 128'(cyc + 1), 128'(4));
        tick();

        lsb_set(1'b0, 32'hFFFFFFFE, 2'b10, 1'b0, 32'h0);
        tick();
        chk("wrap_a0", 128'(bus.mem_a), 128'(32'hFFFFFFFE));
        tick();
        tick();
        chk("wrap_a2", 128'(bus.mem_a), 128'(32'h0));
        wait_done(1'b0, cyc);
        bus.lsb_req = 1'b0;
        chk("wrap_cyc", 128'(cyc + 3), 128'(6));
        chk("wrap_data", 128'(bus.lsb_rdata), 128'(32'h04030201));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Byte-serial sequencer and arbiter for the single 8-bit RAM/IO port, shared between the instruction cache (block refills) and the load/store buffer (1/2/4-byte loads and stores).
- Sits between the icache/LSB and the top-level mem_din/mem_dout/mem_a/mem_wr pins.
- Handles the fixed read latency, UART back-pressure, pipeline flush and rdy_in pauses.

Parameters:
- BLOCK_WIDTH, 2, log2 of words per icache block.
- BLOCK_SIZE, 1<<BLOCK_WIDTH, words per icache block; a refill moves 4*BLOCK_SIZE bytes.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  high = run; low = pause.
- flush_in  in  1  misprediction flush, single-cycle pulse.
- io_buffer_full  in  1  UART TX buffer full.
- mem_din  in  8  RAM read byte; reflects the previous cycle's mem_a.
- mem_dout  out  8  write byte.
- mem_a  out  32  byte address.
- mem_wr  out  1  1 = write.
- icache_req  in  1  refill request, level; held until icache_done.
- icache_addr  in  32  refill address; low 2+BLOCK_WIDTH bits ignored (forced 0).
- icache_done  out  1  one-cycle pulse: icache_data valid.
- icache_data  out  32*BLOCK_SIZE  block; word i in bits [32i+31:32i], little-endian.
- lsb_req  in  1  access request, level; held until lsb_done.
- lsb_we  in  1  1 = store.
- lsb_addr  in  32  byte address.
- lsb_width  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- lsb_signed  in  1  sign-extend load result.
- lsb_wdata  in  32  store data; low bytes used.
- lsb_done  out  1  one-cycle pulse: load data valid or store complete.
- lsb_rdata  out  32  zero- or sign-extended load result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_in=0, async): state IDLE, all outputs 0, last_grant = LSB.
- States and transitions:
  - IDLE: grant selection, see arbitration.
  - IC_RD: N = 4*BLOCK_SIZE bytes.
  - LS_RD: N = 1/2/4 bytes.
  - LS_WR: N = 1/2/4 bytes.
  - Any state returns to IDLE on completion.
- Arbitration (IDLE, rdy_in=1):
  - A requester whose done is high this cycle is ignored.
  - One requester: grant it.
  - Both: grant the one not equal to last_grant (alternate). last_grant updates on grant.
  - Operands are latched at grant.
- Read timing, request sampled in cycle T:
  - mem_a = base+i during cycle T+1+i, for i = 0..N-1.
  - Byte i is captured from mem_din at the end of cycle T+2+i.
  - done pulses in cycle T+N+2. A 4-byte load completes at T+6; a refill with BLOCK_SIZE=4 completes at T+18.
- Write timing:
  - mem_wr=1, mem_a = base+i, mem_dout = byte i of lsb_wdata during cycle T+1+i.
  - lsb_done pulses in T+N+1.
- Address arithmetic: 32-bit wrap; no alignment check for LSB accesses.
- IO writes (mem_a[17:16]==2'b11):
  - If io_buffer_full=1 when a byte would be issued, hold mem_wr=0 and the same byte/address until it clears.
  - Each such stall cycle delays done by 1.
- Load extension:
  - byte: bit 7 extended if lsb_signed, else zero-fill.
  - half: bit 15 extended if lsb_signed, else zero-fill.
  - word: unchanged.
- Pause (rdy_in=0):
  - State, counters and captured bytes frozen; mem_wr forced 0; no done is asserted.
  - mem_a is driven to the oldest uncaptured byte address. The byte returning in the first cycle after the pause is discarded, and issue restarts from that address.
  - Net delay equals pause length + 1.
- Flush (flush_in=1, rdy_in=1):
  - IC_RD and LS_RD abort to IDLE next cycle, with no done and no partial data update.
  - LS_WR (committed store) is never aborted.
  - flush in IDLE blocks granting that cycle.
- Simultaneous events: flush beats grant. Reset beats everything; reset mid-write truncates the write with no done.
- Outputs icache_data/lsb_rdata hold their last value until the next completion.
- mem_dout = 0 and mem_wr = 0 whenever not in LS_WR issue cycles.

Test Plan:
- LSB word load at 0x100, RAM bytes 11,22,33,44, request at T -> mem_a 0x100..0x103 during T+1..T+4, lsb_done at T+6, lsb_rdata=0x44332211.
- Signed byte load of 0x80 -> 0xFFFFFF80; unsigned -> 0x00000080; signed half 0x8001 -> 0xFFFF8001.
- icache_req and lsb_req both rise at T with last_grant=LSB -> icache granted and its done at T+18; LSB granted next, lsb_done 6 cycles later for a word load.
- Store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr asserted once, after full drops; lsb_done delayed 3 cycles.
- rdy_in low for 2 cycles during byte 2 of a word load -> mem_wr=0, no done, correct data 0x44332211 with done delayed 3 cycles.
- flush_in during an icache refill -> IDLE next cycle, no icache_done. flush_in during a halfword store -> store completes, lsb_done pulses.
